lu_sweep_ctrl: RTL and testbench
================================

# lu_sweep_ctrl

Sequencing stage wrapped around the gate-level logic unit (AND/NAND pair plus 2:1 output mux). On `start` it drives all eight `{c, x, y}` input vectors into the logic unit. It samples the unit's output `s` after each vector settles and assembles two 4-bit truth tables, one per select value. It then compares both tables against the expected AND and NAND patterns and reports `pass`.

## Interface
Parameters:
- `SETTLE`, default 1: cycles each vector is held before its sample is taken. Legal range 1..15.
- `EXP_AND`, default 4'b1000: expected table for `c=0`. Bit index is `{x,y}`.
- `EXP_NAND`, default 4'b0111: expected table for `c=1`. Bit index is `{x,y}`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a sweep; honoured only in IDLE or DONE.
- `lu_s`  in  1  logic-unit output `s`, combinational from `x`, `y`, `c`.
- `x`  out  1  operand A to the logic unit.
- `y`  out  1  operand B to the logic unit.
- `c`  out  1  select to the logic unit (0 = AND, 1 = NAND).
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  high from sweep completion until the next accepted start.
- `table_and`  out  4  sampled `s` for `c=0`; bit `i` holds the sample at `{x,y}=i`.
- `table_nand`  out  4  sampled `s` for `c=1`, same indexing.
- `pass`  out  1  valid while `done`=1: (`table_and`==`EXP_AND`) && (`table_nand`==`EXP_NAND`).

## Operation
- States:
  - IDLE: `x`/`y`/`c`=0, `busy`=0, `done`=0.
  - RUN: drive and sample vectors.
  - DONE: `x`/`y`/`c`=0, `done`=1, tables and `pass` held.
- Transitions:
  - IDLE or DONE to RUN: `start`=1 at an edge. The same edge clears `idx`, the settle counter, both tables, `done` and `pass`.
  - RUN to DONE: at the edge that takes the sample for `idx`=7.
- Vector index `idx` is 3 bits, with `{c,x,y}` = `idx`. Order: 0..7, so all AND rows first, then all NAND rows.
- Settle counter: 4 bits, counts 0..SETTLE-1.
  - At the edge where it equals SETTLE-1, `lu_s` is written into table[`c`][`{x,y}`].
  - The same edge resets the counter and increments `idx`.
- `start` during RUN is ignored; there is no queueing.
- `pass` is a registered compare, updated on the RUN to DONE edge. It is 0 in IDLE and RUN.
- Reset values, applied immediately when `rst_n`=0, mid-sweep included: state IDLE, all outputs 0, tables 4'b0000, counters 0.

## Timing
- Start accepted at edge E0. `busy`=1 and vector 0 are on the outputs after E0.
- Vector k is driven from edge E0+k·SETTLE to edge E0+(k+1)·SETTLE.
- Vector k is sampled at edge E0+(k+1)·SETTLE, using the `lu_s` value present just before that edge.
- `busy` stays high for 8·SETTLE cycles.
- `done`/`pass` rise and `busy` falls after edge E0+8·SETTLE.
- Latency from start to done is 8·SETTLE cycles.
- `lu_s` must settle within one clock period of an output change. The logic unit is purely combinational, so no handshake is needed.
- Back-to-back sweeps: a `start` held high in DONE restarts on the next edge, so `done` is high for exactly one cycle.

## Structure
- Package `lu_sweep_pkg`:
  - state enum {IDLE, RUN, DONE};
  - `IDX_W`=3, `CNT_W`=4;
  - default `EXP_AND`/`EXP_NAND` constants.
- Sub-module `lu_settle_timer`: parameter SETTLE, inputs `clk`/`rst_n`/`clear`/`en`, output `tick` high on the terminal count.
- Top level: FSM, `idx` register, table registers and compare.
- The bench instantiates the existing AND, NAND and mux logic unit between `x`/`y`/`c` and `lu_s`.

## Test plan
- Reset: hold `rst_n`=0 with `start`=1 → every output 0 and state IDLE; after release with `start`=0, outputs stay 0.
- Nominal sweep, SETTLE=1, real logic unit: pulse `start` → `{c,x,y}` steps 000..111 on consecutive cycles; `busy` high for 8 cycles; then `table_and`=4'b1000, `table_nand`=4'b0111, `pass`=1, `done`=1.
- Faulty unit, `lu_s` stuck at 0: run a sweep → both tables 4'b0000, `pass`=0, `done`=1 after 8 cycles.
- SETTLE=3: run a sweep → each vector held 3 cycles, `busy` high for 24 cycles, tables 1000/0111, `pass`=1.
- Start during RUN: pulse `start` at vector 4 → no restart, completion still 8 cycles after the original start. Then `start` in DONE → tables clear on the accepting edge and the sweep repeats with identical results.
- Reset mid-sweep: drop `rst_n` during vector 5 → outputs and tables 0 without waiting for a clock edge. After release, a fresh `start` produces a full correct sweep.

Source files
------------

// File: rtl/lu_sweep_pkg.sv
// Shared types and constants for the logic-unit sweep controller.
package lu_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 4;

    localparam logic [3:0] EXP_AND_DEF  = 4'b1000;
    localparam logic [3:0] EXP_NAND_DEF = 4'b0111;

endpackage

// File: rtl/lu_settle_timer.sv
// Settle counter 0..SETTLE-1; tick is a registered flag mirroring the terminal count.
module lu_settle_timer
    import lu_sweep_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE - 1);

    logic [CNT_W-1:0] cnt;

    // tick is computed one cycle ahead so it is high exactly while cnt == LAST
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            tick <= (LAST == '0);
        end else if (en) begin
            if (tick) begin
                cnt  <= '0;
                tick <= (LAST == '0);
            end else begin
                cnt  <= cnt + CNT_W'(1);
                tick <= ((cnt + CNT_W'(1)) == LAST);
            end
        end
    end

endmodule

// File: rtl/lu_sweep_ctrl.sv
// Drives all eight {c,x,y} vectors into the logic unit, records both truth tables
// and compares them against the expected AND / NAND patterns.
module lu_sweep_ctrl
    import lu_sweep_pkg::*;
#(
    parameter int unsigned SETTLE   = 1,
    parameter logic [3:0]  EXP_AND  = EXP_AND_DEF,
    parameter logic [3:0]  EXP_NAND = EXP_NAND_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       lu_s,
    output logic       x,
    output logic       y,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic [3:0] table_and,
    output logic [3:0] table_nand,
    output logic       pass
);

    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    state_e           state;
    logic [IDX_W-1:0] idx;
    logic             tick;
    logic             accept;
    logic             run_en;
    logic             sample;
    logic [3:0]       and_upd;
    logic [3:0]       nand_upd;

    assign run_en = (state == RUN);
    assign accept = start && (state != RUN);
    assign sample = run_en && tick;

    lu_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (accept),
        .en    (run_en),
        .tick  (tick)
    );

    // Tables including the sample taken at this edge, so pass sees the final row
    always_comb begin
        and_upd  = table_and;
        nand_upd = table_nand;
        if (sample) begin
            if (idx[2]) nand_upd[idx[1:0]] = lu_s;
            else        and_upd[idx[1:0]]  = lu_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            x          <= 1'b0;
            y          <= 1'b0;
            c          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            table_and  <= '0;
            table_nand <= '0;
            pass       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= RUN;
                        idx         <= '0;
                        {c, x, y}   <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        table_and   <= '0;
                        table_nand  <= '0;
                    end
                end
                RUN: begin
                    if (tick) begin
                        table_and  <= and_upd;
                        table_nand <= nand_upd;
                        if (idx == LAST_IDX) begin
                            state     <= DONE;
                            idx       <= '0;
                            {c, x, y} <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            pass      <= (and_upd == EXP_AND) && (nand_upd == EXP_NAND);
                        end else begin
                            idx       <= idx + IDX_W'(1);
                            {c, x, y} <= idx + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lu_sweep_ctrl.sv
// Bench for lu_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) around a gate-level logic unit.
module tb_lu_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_a;
    logic start_b;
    logic fault;

    logic       xa, ya, ca, busy_a, done_a, pass_a, lu_s_a;
    logic [3:0] tand_a, tnand_a;
    logic       xb, yb, cb, busy_b, done_b, pass_b, lu_s_b;
    logic [3:0] tand_b, tnand_b;

    // Logic unit: AND / NAND pair with a 2:1 mux on c; fault forces s stuck at 0
    logic and_a, nand_a, and_b, nand_b;
    assign and_a  = xa & ya;
    assign nand_a = ~(xa & ya);
    assign lu_s_a = fault ? 1'b0 : (ca ? nand_a : and_a);
    assign and_b  = xb & yb;
    assign nand_b = ~(xb & yb);
    assign lu_s_b = cb ? nand_b : and_b;

    lu_sweep_ctrl #(.SETTLE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .lu_s(lu_s_a),
        .x(xa), .y(ya), .c(ca), .busy(busy_a), .done(done_a),
        .table_and(tand_a), .table_nand(tnand_a), .pass(pass_a)
    );

    lu_sweep_ctrl #(.SETTLE(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .lu_s(lu_s_b),
        .x(xb), .y(yb), .c(cb), .busy(busy_b), .done(done_b),
        .table_and(tand_b), .table_nand(tnand_b), .pass(pass_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {c,x,y, busy, done, table_and, table_nand, pass}
    function automatic logic [13:0] obs_a();
        return {ca, xa, ya, busy_a, done_a, tand_a, tnand_a, pass_a};
    endfunction

    function automatic logic [13:0] obs_b();
        return {cb, xb, yb, busy_b, done_b, tand_b, tnand_b, pass_b};
    endfunction

    function automatic logic [13:0] ex(input logic [2:0] cxy, input logic b, input logic d,
                                       input logic [3:0] ta, input logic [3:0] tn, input logic p);
        return {cxy, b, d, ta, tn, p};
    endfunction

    typedef struct {
        logic       rst_n;
        logic       start;
        logic       fault;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[34];

    function automatic vec_t mk(input logic r, input logic s, input logic f, input logic [13:0] e);
        vec_t v;
        v.rst_n = r;
        v.start = s;
        v.fault = f;
        v.exp   = e;
        return v;
    endfunction

    // One sweep on the SETTLE=1 instance, optionally pulsing start at a given vector
    task automatic run_a(input string tag, input int pulse_at);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        chk($sformatf("%s_accept", tag), 32'(obs_a()), 32'(ex(3'd0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0)));
        for (int j = 1; j <= 8; j++) begin
            start_a = (j == pulse_at + 1) && (pulse_at > 0);
            @(posedge clk); #1;
            start_a = 1'b0;
            if (j < 8)
                chk($sformatf("%s_run%0d", tag, j), 32'({ca, xa, ya, busy_a, done_a}),
                    32'({3'(j), 1'b1, 1'b0}));
            else
                chk($sformatf("%s_done", tag), 32'(obs_a()),
                    32'(ex(3'd0, 1'b0, 1'b1, 4'h8, 4'h7, 1'b1)));
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b1;
        start_b = 1'b0;
        fault   = 1'b0;

        vecs[0]  = mk(0, 1, 0, ex(3'd0, 0, 0, 4'h0, 4'h0, 0));
        vecs[1]  = mk(0, 1, 0, ex(3'd0, 0, 0, 4'h0, 4'h0, 0));
        vecs[2]  = mk(1, 0, 0, ex(3'd0, 0, 0, 4'h0, 4'h0, 0));
        vecs[3]  = mk(1, 0, 0, ex(3'd0, 0, 0, 4'h0, 4'h0, 0));
        vecs[4]  = mk(1, 1, 0, ex(3'd0, 1, 0, 4'h0, 4'h0, 0));
        vecs[5]  = mk(1, 0, 0, ex(3'd1, 1, 0, 4'h0, 4'h0, 0));
        vecs[6]  = mk(1, 0, 0, ex(3'd2, 1, 0, 4'h0, 4'h0, 0));
        vecs[7]  = mk(1, 0, 0, ex(3'd3, 1, 0, 4'h0, 4'h0, 0));
        vecs[8]  = mk(1, 0, 0, ex(3'd4, 1, 0, 4'h8, 4'h0, 0));
        vecs[9]  = mk(1, 0, 0, ex(3'd5, 1, 0, 4'h8, 4'h1, 0));
        vecs[10] = mk(1, 0, 0, ex(3'd6, 1, 0, 4'h8, 4'h3, 0));
        vecs[11] = mk(1, 0, 0, ex(3'd7, 1, 0, 4'h8, 4'h7, 0));
        vecs[12] = mk(1, 0, 0, ex(3'd0, 0, 1, 4'h8, 4'h7, 1));
        vecs[13] = mk(1, 0, 0, ex(3'd0, 0, 1, 4'h8, 4'h7, 1));
        vecs[14] = mk(1, 1, 1, ex(3'd0, 1, 0, 4'h0, 4'h0, 0));
        for (int i = 15; i <= 21; i++)
            vecs[i] = mk(1, 0, 1, ex(3'(i - 14), 1, 0, 4'h0, 4'h0, 0));
        vecs[22] = mk(1, 0, 1, ex(3'd0, 0, 1, 4'h0, 4'h0, 0));
        vecs[23] = mk(1, 1, 0, ex(3'd0, 1, 0, 4'h0, 4'h0, 0));
        vecs[24] = mk(1, 1, 0, ex(3'd1, 1, 0, 4'h0, 4'h0, 0));
        vecs[25] = mk(1, 1, 0, ex(3'd2, 1, 0, 4'h0, 4'h0, 0));
        vecs[26] = mk(1, 1, 0, ex(3'd3, 1, 0, 4'h0, 4'h0, 0));
        vecs[27] = mk(1, 1, 0, ex(3'd4, 1, 0, 4'h8, 4'h0, 0));
        vecs[28] = mk(1, 1, 0, ex(3'd5, 1, 0, 4'h8, 4'h1, 0));
        vecs[29] = mk(1, 1, 0, ex(3'd6, 1, 0, 4'h8, 4'h3, 0));
        vecs[30] = mk(1, 1, 0, ex(3'd7, 1, 0, 4'h8, 4'h7, 0));
        vecs[31] = mk(1, 1, 0, ex(3'd0, 0, 1, 4'h8, 4'h7, 1));
        vecs[32] = mk(1, 1, 0, ex(3'd0, 1, 0, 4'h0, 4'h0, 0));
        vecs[33] = mk(0, 0, 0, ex(3'd0, 0, 0, 4'h0, 4'h0, 0));

        for (int i = 0; i < 34; i++) begin
            rst_n   = vecs[i].rst_n;
            start_a = vecs[i].start;
            fault   = vecs[i].fault;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), 32'(obs_a()), 32'(vecs[i].exp));
        end
        chk("b_idle_after_reset", 32'(obs_b()), 32'(ex(3'd0, 0, 0, 4'h0, 4'h0, 0)));

        // SETTLE=3: each vector held three cycles, busy for 24
        rst_n   = 1'b1;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        chk("s3_accept", 32'({cb, xb, yb, busy_b, done_b}), 32'({3'd0, 1'b1, 1'b0}));
        for (int j = 1; j <= 24; j++) begin
            @(posedge clk); #1;
            if (j < 24)
                chk($sformatf("s3_run%0d", j), 32'({cb, xb, yb, busy_b, done_b}),
                    32'({3'(j / 3), 1'b1, 1'b0}));
            else
                chk("s3_done", 32'(obs_b()), 32'(ex(3'd0, 0, 1, 4'h8, 4'h7, 1)));
        end

        // start during RUN ignored, then restart from DONE clears and repeats
        run_a("midstart", 4);
        run_a("restart", 0);

        // asynchronous reset while vector 5 is driven
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_reset_vec5", 32'({ca, xa, ya, busy_a}), 32'({3'd5, 1'b1}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_a", 32'(obs_a()), 32'(ex(3'd0, 0, 0, 4'h0, 4'h0, 0)));
        chk("async_reset_b", 32'(obs_b()), 32'(ex(3'd0, 0, 0, 4'h0, 4'h0, 0)));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle", 32'(obs_a()), 32'(ex(3'd0, 0, 0, 4'h0, 4'h0, 0)));
        run_a("fresh", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
